// File: rtl/apbDecode_package.sv
// Shared types for the APB initiator: FSM states, captured command and response records.
// Optional write strobes are compiled in with APB_INITIATOR_PSTRB_EN.
package apbDecode_package;

   localparam int unsigned APB_INIT_ADDR_W          = 32;
   localparam int unsigned APB_INIT_DATA_W          = 32;
   localparam int unsigned APB_INIT_TIMEOUT_DEFAULT = 256;

   typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} apbInitStateT;

   typedef struct packed {
      logic                         write;
      logic [APB_INIT_ADDR_W-1:0]   addr;
      logic [APB_INIT_DATA_W-1:0]   wdata;
`ifdef APB_INITIATOR_PSTRB_EN
      logic [APB_INIT_DATA_W/8-1:0] strb;
`endif
   } apbInitReqSt;

   typedef struct packed {
      logic [APB_INIT_DATA_W-1:0] rdata;
      logic                       err;
      logic                       timeout;
   } apbInitRspSt;

endpackage

// File: rtl/apb_initiator.sv
// APB requester: one command -> SETUP + ACCESS -> response; rsp_valid 3 cycles after accept with pready high,
// one transfer outstanding (req_ready low until the response is taken); APB_INITIATOR_PSTRB_EN adds pstrb.
module apb_initiator
   import apbDecode_package::*;
#(
   parameter int unsigned ADDR_W  = APB_INIT_ADDR_W,
   parameter int unsigned DATA_W  = APB_INIT_DATA_W,
   parameter int unsigned TIMEOUT = APB_INIT_TIMEOUT_DEFAULT
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                req_valid,
   output logic                req_ready,
   input  logic                req_write,
   input  logic [ADDR_W-1:0]   req_addr,
   input  logic [DATA_W-1:0]   req_wdata,
`ifdef APB_INITIATOR_PSTRB_EN
   input  logic [DATA_W/8-1:0] req_strb,
   output logic [DATA_W/8-1:0] pstrb,
`endif
   output logic                rsp_valid,
   input  logic                rsp_ready,
   output logic [DATA_W-1:0]   rsp_rdata,
   output logic                rsp_err,
   output logic                rsp_timeout,
   output logic                psel,
   output logic                penable,
   output logic                pwrite,
   output logic [ADDR_W-1:0]   paddr,
   output logic [DATA_W-1:0]   pwdata,
   input  logic [DATA_W-1:0]   prdata,
   input  logic                pready,
   input  logic                pslverr
);

   // Counter only ever needs to reach TIMEOUT-1; keep at least one bit when the timeout is disabled.
   localparam int unsigned CNT_W     = (TIMEOUT == 0) ? 1 : $clog2(TIMEOUT + 1);
   localparam int unsigned TO_LAST_I = (TIMEOUT == 0) ? 0 : TIMEOUT - 1;
   localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TO_LAST_I);

   apbInitStateT     state_q;
   apbInitStateT     state_d;
   apbInitReqSt      req_q;
   apbInitRspSt      rsp_q;
   logic [CNT_W-1:0] cnt_q;
   logic             timeout_hit;

   assign timeout_hit = (TIMEOUT != 0) && (cnt_q == TO_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // pready wins over the timeout when both land in the same ACCESS cycle.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         IDLE:    if (req_valid)              state_d = SETUP;
         SETUP:                               state_d = ACCESS;
         ACCESS:  if (pready || timeout_hit)  state_d = RESP;
         RESP:    if (rsp_ready)              state_d = IDLE;
         default:                             state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         req_q <= '0;
         rsp_q <= '0;
         cnt_q <= '0;
      end else begin
         unique case (state_q)
            IDLE: begin
               if (req_valid) begin
                  req_q.write <= req_write;
                  req_q.addr  <= req_addr;
                  req_q.wdata <= req_wdata;
`ifdef APB_INITIATOR_PSTRB_EN
                  req_q.strb  <= req_write ? req_strb : '0;
`endif
               end
            end
            SETUP: cnt_q <= '0;
            ACCESS: begin
               if (pready) begin
                  rsp_q.rdata   <= req_q.write ? '0 : prdata;
                  rsp_q.err     <= pslverr;
                  rsp_q.timeout <= 1'b0;
               end else if (timeout_hit) begin
                  rsp_q.rdata   <= '0;
                  rsp_q.err     <= 1'b1;
                  rsp_q.timeout <= 1'b1;
               end else if (cnt_q != '1) begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            default: ;
         endcase
      end
   end

   assign req_ready   = (state_q == IDLE) && !rst;
   assign psel        = (state_q == SETUP) || (state_q == ACCESS);
   assign penable     = (state_q == ACCESS);
   assign pwrite      = req_q.write;
   assign paddr       = req_q.addr;
   assign pwdata      = req_q.wdata;
`ifdef APB_INITIATOR_PSTRB_EN
   assign pstrb       = req_q.strb;
`endif
   assign rsp_valid   = (state_q == RESP);
   assign rsp_rdata   = rsp_q.rdata;
   assign rsp_err     = rsp_q.err;
   assign rsp_timeout = rsp_q.timeout;

endmodule

// File: tb/tb_apb_initiator.sv
// Bench for apb_initiator: directed scenarios plus random commands against a transaction-level model
// of expected timing (accept -> SETUP -> ACCESS cycles) and response contents.
module tb_apb_initiator;

   localparam int TMO = 8;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid, req_ready, req_write;
   logic [31:0] req_addr, req_wdata;
   logic        rsp_valid, rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_err, rsp_timeout;
   logic        psel, penable, pwrite;
   logic [31:0] paddr, pwdata, prdata;
   logic        pready, pslverr;
`ifdef APB_INITIATOR_PSTRB_EN
   logic [3:0]  req_strb, pstrb;
`endif

   int n_checks = 0;
   int n_errors = 0;

   apb_initiator #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(TMO)) dut (
      .clk(clk), .rst(rst),
      .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
      .req_addr(req_addr), .req_wdata(req_wdata),
`ifdef APB_INITIATOR_PSTRB_EN
      .req_strb(req_strb), .pstrb(pstrb),
`endif
      .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
      .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
      .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr), .pwdata(pwdata),
      .prdata(prdata), .pready(pready), .pslverr(pslverr)
   );

   always #5 clk = ~clk;

   initial begin
      #300000;
      $display("FAIL watchdog: time limit reached, got no finish, expected finish");
      $fatal(1, "watchdog");
   end

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // One command from accept to response handshake. The completer raises pready after w wait cycles;
   // if w reaches TMO the initiator must abort after exactly TMO ACCESS cycles.
   task automatic run_txn(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] rd, input int w, input bit slv, input int hold);
      bit          timed;
      int          exp_acc, acc;
      logic [31:0] exp_rdata;
      bit          exp_err;
      logic [3:0]  strb;
      timed     = (w >= TMO);
      exp_acc   = timed ? TMO : w + 1;
      exp_rdata = (timed || wr) ? 32'h0 : rd;
      exp_err   = timed || slv;
      strb      = 4'($urandom);

      req_valid = 1'b1; req_write = wr; req_addr = addr; req_wdata = wdata;
`ifdef APB_INITIATOR_PSTRB_EN
      req_strb  = strb;
`endif
      #1;
      for (int i = 0; i < 10 && !req_ready; i++) @(negedge clk);
      check("accept_req_ready", req_ready, 1);

      // SETUP: inputs scrambled from here on must be ignored
      @(negedge clk);
      req_valid = 1'($urandom); req_write = 1'($urandom);
      req_addr = $urandom; req_wdata = $urandom;
      check("setup_psel", psel, 1);
      check("setup_penable", penable, 0);
      check("setup_pwrite", pwrite, wr);
      check("setup_paddr", paddr, addr);
      check("setup_pwdata", pwdata, wdata);
      check("setup_req_ready", req_ready, 0);
      check("setup_rsp_valid", rsp_valid, 0);
`ifdef APB_INITIATOR_PSTRB_EN
      check("setup_pstrb", pstrb, wr ? strb : 4'h0);
`endif

      @(negedge clk);
      acc = 0;
      while (penable === 1'b1 && acc < 40) begin
         acc++;
         check("access_psel", psel, 1);
         check("access_paddr", paddr, addr);
         check("access_pwrite", pwrite, wr);
         check("access_req_ready", req_ready, 0);
         pready  = (acc - 1 == w);
         prdata  = pready ? rd : $urandom;
         pslverr = pready ? slv : 1'($urandom);
         req_addr = $urandom;
         @(negedge clk);
      end
      // late completer activity after the transfer ends must have no effect
      pready = 1'($urandom); pslverr = 1'($urandom); prdata = $urandom;
      check("access_cycles", acc, exp_acc);
      check("after_psel", psel, 0);
      check("after_penable", penable, 0);

      for (int h = 0; h <= hold; h++) begin
         rsp_ready = (h == hold);
         req_valid = 1'b1;
         #1;
         check("rsp_valid", rsp_valid, 1);
         check("rsp_rdata", rsp_rdata, exp_rdata);
         check("rsp_err", rsp_err, exp_err);
         check("rsp_timeout", rsp_timeout, timed);
         check("rsp_req_ready", req_ready, 0);
         @(negedge clk);
      end
      rsp_ready = 1'b0;
      pready    = 1'b0;
      check("rsp_valid_clear", rsp_valid, 0);
   endtask

   initial begin
      rst = 1'b1; req_valid = 1'b0; req_write = 1'b0; req_addr = '0; req_wdata = '0;
      rsp_ready = 1'b0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
`ifdef APB_INITIATOR_PSTRB_EN
      req_strb = '0;
`endif
      repeat (3) @(negedge clk);
      check("rst_psel", psel, 0);
      check("rst_penable", penable, 0);
      check("rst_pwrite", pwrite, 0);
      check("rst_paddr", paddr, 0);
      check("rst_pwdata", pwdata, 0);
      check("rst_rsp_valid", rsp_valid, 0);
      check("rst_rsp_rdata", rsp_rdata, 0);
      check("rst_rsp_err", rsp_err, 0);
      check("rst_rsp_timeout", rsp_timeout, 0);
      check("rst_req_ready", req_ready, 0);
      rst = 1'b0;
      #1;
      check("post_rst_req_ready", req_ready, 1);
      @(negedge clk);

      run_txn(1'b1, 32'h0000_0010, 32'hDEAD_BEEF, 32'h0, 0, 1'b0, 0);
      run_txn(1'b0, 32'h0000_0004, 32'h0, 32'h1234_5678, 5, 1'b0, 0);
      run_txn(1'b0, 32'h0000_0008, 32'h0, 32'hCAFE_0001, 0, 1'b1, 1);
      run_txn(1'b0, 32'h0000_000C, 32'h0, 32'hFFFF_FFFF, 1000, 1'b0, 0);
      run_txn(1'b1, 32'h0000_0020, 32'h5555_AAAA, 32'h0, 0, 1'b0, 10);
      run_txn(1'b0, 32'h0000_0024, 32'h0, 32'h0BAD_F00D, TMO - 1, 1'b1, 0);

      for (int t = 0; t < 60; t++) begin
         int w, gap;
         w   = ($urandom % 5 == 0) ? $urandom_range(TMO - 1, TMO + 4) : $urandom_range(0, 3);
         gap = $urandom_range(0, 2);
         run_txn(1'($urandom), $urandom & 32'hFFFF_FFFC, $urandom, $urandom, w,
                 1'($urandom), $urandom_range(0, 3));
         for (int g = 0; g < gap; g++) begin
            req_valid = 1'b0;
            req_addr  = $urandom;
            #1;
            check("gap_req_ready", req_ready, 1);
            check("gap_psel", psel, 0);
            @(negedge clk);
         end
      end

      // reset while in ACCESS: transfer discarded, no response
      req_valid = 1'b1; req_write = 1'b0; req_addr = 32'h40; pready = 1'b0;
      @(negedge clk);
      req_valid = 1'b0;
      @(negedge clk);
      @(negedge clk);
      check("midrst_in_access", penable, 1);
      rst = 1'b1;
      @(negedge clk);
      check("midrst_psel", psel, 0);
      check("midrst_penable", penable, 0);
      check("midrst_rsp_valid", rsp_valid, 0);
      check("midrst_req_ready", req_ready, 0);
      rst = 1'b0;
      #1;
      check("midrst_release_req_ready", req_ready, 1);
      @(negedge clk);
      check("midrst_no_rsp", rsp_valid, 0);
      check("midrst_idle_psel", psel, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/apb_initiator.md
Name: apb_initiator

Overview:
- APB requester that drives the slave-side register decoders (the `apb_if.dst` ports of block register files) from a simple valid/ready command channel.
- Converts each accepted command into one APB SETUP and ACCESS transfer, then returns read data and error status on a valid/ready response channel.
- Includes an access timeout so that a hung completer cannot stall the system.
- Used by test harnesses and by on-chip config sequencers.

Parameters:
- ADDR_W, 32, width of paddr and req_addr
- DATA_W, 32, width of pwdata, prdata, req_wdata and rsp_rdata
- TIMEOUT, 256, maximum number of ACCESS cycles before abort; 0 disables the timeout

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- req_valid  in  1  command valid
- req_ready  out  1  command accepted when high with req_valid
- req_write  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  byte address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  response valid
- rsp_ready  in  1  response consumed
- rsp_rdata  out  DATA_W  read data; 0 for writes
- rsp_err  out  1  pslverr was sampled, or the transfer timed out
- rsp_timeout  out  1  the transfer timed out
- psel  out  1  APB select
- penable  out  1  APB enable
- pwrite  out  1  APB direction
- paddr  out  ADDR_W  APB address
- pwdata  out  DATA_W  APB write data
- prdata  in  DATA_W  APB read data
- pready  in  1  APB ready
- pslverr  in  1  APB error

Behaviour:
- Reset values: state IDLE; psel, penable, pwrite, paddr and pwdata all 0; rsp_valid, rsp_rdata, rsp_err and rsp_timeout all 0; req_ready 0 during reset, 1 in the first cycle after reset.
- FSM states: IDLE, SETUP, ACCESS, RESP.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, capture write, addr and wdata into registers and go to SETUP.
- SETUP (exactly 1 cycle):
  - psel = 1, penable = 0; pwrite, paddr and pwdata driven from the captured registers.
  - Go to ACCESS.
  - Clear the timeout counter.
- ACCESS:
  - psel = 1, penable = 1; all other APB outputs held stable.
  - If pready = 1: sample prdata (reads only; writes return 0) and pslverr into the response registers, set rsp_timeout = 0, drop psel and penable on the next cycle, and go to RESP.
  - Otherwise increment the counter.
  - If TIMEOUT != 0 and the counter reaches TIMEOUT-1 with pready still low: drop psel and penable, set rsp_err = 1, rsp_timeout = 1 and rsp_rdata = 0, and go to RESP.
  - pready has priority over timeout in the same cycle.
- RESP:
  - rsp_valid = 1 and the response fields are held stable.
  - On rsp_ready, go to IDLE.
  - req_ready = 0 until the cycle after the handshake, so there is at most one transfer outstanding.
- Latency:
  - With pready tied high, accept at cycle N, SETUP at N+1, ACCESS at N+2, rsp_valid at N+3.
  - Minimum command-to-command period is 4 cycles, given rsp_ready = 1.
- Outputs are registered. psel, penable and paddr never change mid-transfer.
- Counter width is $clog2(TIMEOUT+1), with a minimum of 1. It saturates and never wraps.
- Reset mid-transfer: psel and penable drop on the next cycle, the transfer is discarded and no response is issued.
- Input changes while busy: req_* inputs are ignored outside IDLE. A pslverr sampled while pready = 0 is ignored.
- A late pready after a timeout abort is ignored, because psel is already low.

Optional Feature:
- Macro: APB_INITIATOR_PSTRB_EN.
- When defined:
  - Adds input req_strb [DATA_W/8] and output pstrb [DATA_W/8].
  - req_strb is captured on accept; pstrb is driven from the captured value during writes and forced to 0 during reads.
  - pstrb resets to 0.
- When undefined: neither port exists, and all writes are full-word.

Decomposition:
- Shared package apbDecode_package holds:
  - enum apbInitStateT {IDLE, SETUP, ACCESS, RESP};
  - packed structs apbInitReqSt (write, addr, wdata[, strb]) and apbInitRspSt (rdata, err, timeout);
  - constant APB_INIT_TIMEOUT_DEFAULT = 256.
- Single module, no sub-module: the FSM, capture registers and timeout counter are too small to justify one.

Test Plan:
- Write addr 0x0000_0010, data 0xDEAD_BEEF, pready=1 -> one SETUP cycle then one ACCESS cycle with pwrite=1; rsp_valid 3 cycles after accept; rsp_err=0, rsp_rdata=0.
- Read addr 0x0000_0004, pready low for 5 ACCESS cycles then high with prdata=0x1234_5678 -> penable high for 6 cycles; rsp_rdata=0x1234_5678, rsp_err=0.
- Read with pslverr=1 at pready -> rsp_err=1, rsp_timeout=0.
- TIMEOUT=8, pready never asserted -> psel drops after 8 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0; next command accepted after rsp_ready.
- rsp_ready held low for 10 cycles with req_valid high -> req_ready=0 throughout, response stable; second command accepted the cycle after the rsp handshake.
- rst asserted in ACCESS -> next cycle psel=0, penable=0, rsp_valid=0; after reset release req_ready=1.
